// File: rtl/rgb2hsv_stream.sv
// rgb2hsv_stream: one-pixel-at-a-time RGB to HSV/HSL converter.
//
// A pixel is accepted in IDLE. It then takes one cycle for max/min, one
// cycle to set up the divide operands, W restoring-divide iterations plus
// one finishing cycle that applies the hue offset. The result is then held
// until the consumer takes it.
//
// Ports:
//   clock     - single clock, rising edge
//   reset     - synchronous, active-low
//   in_valid  - r/g/b/mode carry a pixel
//   in_ready  - block is idle and will take a pixel
//   r, g, b   - unsigned W-bit colour channels
//   mode      - 0: HSV, 1: HSL (third output becomes lightness)
//   out_valid - h/s/v hold a result
//   out_ready - consumer takes the result
//   h, s, v   - hue, saturation, value or lightness (W bits each)
module rgb2hsv_stream #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] r,
    input  logic [W-1:0] g,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] h,
    output logic [W-1:0] s,
    output logic [W-1:0] v
);

    localparam int MAXV = (1 << W) - 1;
    // Wide enough for 6*delta shifted left by W-1.
    localparam int DW = 2 * W + 3;
    localparam int CW = $clog2(W + 1);
    localparam logic [DW-1:0] MAXV_D = DW'(MAXV);
    localparam logic [W:0]    MAXV_S = (W + 1)'(MAXV);
    localparam logic [W+1:0]  MAXV_H = (W + 2)'(MAXV);
    localparam logic [W+1:0]  OFF_G  = (W + 2)'(MAXV / 3);
    localparam logic [W+1:0]  OFF_B  = (W + 2)'(2 * MAXV / 3);
    localparam logic [CW-1:0] LAST   = CW'(W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MINMAX = 3'd1,
        SETUP  = 3'd2,
        DIVIDE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state_r;
    logic          in_ready_r, out_valid_r, mode_r;
    logic [W-1:0]  rl_r, gl_r, bl_r, max_r, min_r;
    logic [1:0]    sel_r;
    logic [DW-1:0] rem_s_r, rem_h_r, dsh_s_r, dsh_h_r;
    logic [W-1:0]  qs_r, qh_r, vres_r, h_r, s_r, v_r;
    logic          zs_r, zh_r, neg_r;
    logic [W+1:0]  off_r;
    logic [CW-1:0] cnt_r;

    logic [W-1:0]  max_s, min_s;
    logic [1:0]    sel_s;
    logic [W-1:0]  delta_s, pa_s, pb_s, adiff_s, vres_s;
    logic [W:0]    sum_s, sden_s;
    logic          neg_s;
    logic [W+1:0]  off_s;
    logic [DW-1:0] snum_s, hnum_s, hden_s;
    logic [W-1:0]  qs_f_s;
    logic [W+1:0]  qh_w_s, hue_w_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign h = h_r;
    assign s = s_r;
    assign v = v_r;

    // Max/min of the latched pixel; ties for max go r, then g, then b.
    always_comb begin
        max_s = bl_r;
        sel_s = 2'd2;
        min_s = bl_r;
        if (rl_r >= gl_r && rl_r >= bl_r) begin
            max_s = rl_r;
            sel_s = 2'd0;
        end else if (gl_r >= bl_r) begin
            max_s = gl_r;
            sel_s = 2'd1;
        end else begin
            max_s = bl_r;
            sel_s = 2'd2;
        end
        if (rl_r <= gl_r && rl_r <= bl_r) begin
            min_s = rl_r;
        end else if (gl_r <= bl_r) begin
            min_s = gl_r;
        end else begin
            min_s = bl_r;
        end
    end

    // Divide operands for saturation and hue, built from max/min.
    always_comb begin
        delta_s = max_r - min_r;
        sum_s   = {1'b0, max_r} + {1'b0, min_r};
        if (!mode_r) begin
            sden_s = {1'b0, max_r};
            vres_s = max_r;
        end else if (sum_s <= MAXV_S) begin
            sden_s = sum_s;
            vres_s = sum_s[W:1];
        end else begin
            // 2*MAXV - sum, written so no intermediate exceeds W+1 bits.
            sden_s = MAXV_S - (sum_s - MAXV_S);
            vres_s = sum_s[W:1];
        end
        case (sel_r)
            2'd0: begin
                pa_s  = gl_r;
                pb_s  = bl_r;
                off_s = '0;
            end
            2'd1: begin
                pa_s  = bl_r;
                pb_s  = rl_r;
                off_s = OFF_G;
            end
            default: begin
                pa_s  = rl_r;
                pb_s  = gl_r;
                off_s = OFF_B;
            end
        endcase
        neg_s = (pa_s < pb_s);
        if (neg_s) begin
            adiff_s = pb_s - pa_s;
        end else begin
            adiff_s = pa_s - pb_s;
        end
        snum_s = MAXV_D * DW'(delta_s);
        hnum_s = MAXV_D * DW'(adiff_s);
        hden_s = (DW'(delta_s) << 2) + (DW'(delta_s) << 1);
    end

    // Final quotients with zero divisors forced to 0, and hue at W+2 bits.
    always_comb begin
        qs_f_s = zs_r ? '0 : qs_r;
        qh_w_s = zh_r ? '0 : {2'b00, qh_r};
        if (neg_r && qh_w_s > off_r) begin
            hue_w_s = MAXV_H - qh_w_s + off_r;
        end else if (neg_r) begin
            hue_w_s = off_r - qh_w_s;
        end else begin
            hue_w_s = off_r + qh_w_s;
        end
    end

    // Control FSM, operand registers, dual restoring divider and outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            mode_r      <= 1'b0;
            rl_r        <= '0;
            gl_r        <= '0;
            bl_r        <= '0;
            max_r       <= '0;
            min_r       <= '0;
            sel_r       <= 2'd0;
            rem_s_r     <= '0;
            rem_h_r     <= '0;
            dsh_s_r     <= '0;
            dsh_h_r     <= '0;
            qs_r        <= '0;
            qh_r        <= '0;
            zs_r        <= 1'b0;
            zh_r        <= 1'b0;
            neg_r       <= 1'b0;
            off_r       <= '0;
            vres_r      <= '0;
            cnt_r       <= '0;
            h_r         <= '0;
            s_r         <= '0;
            v_r         <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    if (in_valid && in_ready_r) begin
                        rl_r       <= r;
                        gl_r       <= g;
                        bl_r       <= b;
                        mode_r     <= mode;
                        in_ready_r <= 1'b0;
                        state_r    <= MINMAX;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                MINMAX: begin
                    max_r   <= max_s;
                    min_r   <= min_s;
                    sel_r   <= sel_s;
                    state_r <= SETUP;
                end
                SETUP: begin
                    // Divisors start aligned to the quotient MSB.
                    rem_s_r <= snum_s;
                    rem_h_r <= hnum_s;
                    dsh_s_r <= DW'(sden_s) << (W - 1);
                    dsh_h_r <= hden_s << (W - 1);
                    zs_r    <= (sden_s == '0);
                    zh_r    <= (delta_s == '0);
                    neg_r   <= neg_s;
                    off_r   <= off_s;
                    vres_r  <= vres_s;
                    qs_r    <= '0;
                    qh_r    <= '0;
                    cnt_r   <= '0;
                    state_r <= DIVIDE;
                end
                DIVIDE: begin
                    if (cnt_r == LAST) begin
                        // Extra cycle after the W iterations applies the offset.
                        h_r         <= hue_w_s[W-1:0];
                        s_r         <= qs_f_s;
                        v_r         <= vres_r;
                        out_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end else begin
                        if (rem_s_r >= dsh_s_r) begin
                            rem_s_r <= rem_s_r - dsh_s_r;
                            qs_r    <= {qs_r[W-2:0], 1'b1};
                        end else begin
                            qs_r    <= {qs_r[W-2:0], 1'b0};
                        end
                        if (rem_h_r >= dsh_h_r) begin
                            rem_h_r <= rem_h_r - dsh_h_r;
                            qh_r    <= {qh_r[W-2:0], 1'b1};
                        end else begin
                            qh_r    <= {qh_r[W-2:0], 1'b0};
                        end
                        dsh_s_r <= dsh_s_r >> 1;
                        dsh_h_r <= dsh_h_r >> 1;
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Directed bench for rgb2hsv_stream at W=8 with hand-computed results.
module tb_rgb2hsv_stream;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] r = 8'd0;
    logic [7:0] g = 8'd0;
    logic [7:0] b = 8'd0;
    logic       mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] h, s, v;

    int passed = 0;
    int total  = 0;

    rgb2hsv_stream #(.W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .h(h), .s(s), .v(v)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Waits for in_ready, offers one pixel, checks latency and results.
    // Leaves the DUT in HOLD (out_ready low) so callers can test backpressure.
    task automatic send(input string tag, input logic [7:0] ir, input logic [7:0] ig,
                        input logic [7:0] ib, input logic im);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        r = ir; g = ig; b = ib; mode = im; in_valid = 1'b1;
        @(negedge clock);
        // Junk inputs while busy must be ignored.
        r = 8'hA5; g = 8'h3C; b = 8'h0F; mode = ~im;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd11);
    endtask

    task automatic expect_hsv(input string tag, input logic [7:0] eh,
                              input logic [7:0] es, input logic [7:0] ev);
        chk({tag, "_hsv"}, {8'd0, h, s, v}, {8'd0, eh, es, ev});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_rel"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    logic [7:0] vr [15];
    logic [7:0] vg [15];
    logic [7:0] vb [15];
    logic       vm [15];
    logic [7:0] eh [15];
    logic [7:0] es [15];
    logic [7:0] ev [15];

    initial begin
        logic [31:0] snap;
        int seen;
        // r, g, b, mode -> h, s, v
        vr = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0, 8'd128, 8'd255, 8'd255,
               8'd200, 8'd100, 8'd150, 8'd50,  8'd200, 8'd250, 8'd0};
        vg = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd0, 8'd128, 8'd0,   8'd255,
               8'd100, 8'd200, 8'd200, 8'd100, 8'd100, 8'd200, 8'd255};
        vb = '{8'd0,   8'd0,   8'd255, 8'd255, 8'd0, 8'd128, 8'd0,   8'd255,
               8'd50,  8'd150, 8'd100, 8'd200, 8'd50,  8'd100, 8'd255};
        vm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        eh = '{8'd0,   8'd85,  8'd170, 8'd213, 8'd0, 8'd0,   8'd0,   8'd0,
               8'd14,  8'd106, 8'd64,  8'd156, 8'd14, 8'd28, 8'd127};
        es = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0,   8'd255, 8'd0,
               8'd191, 8'd127, 8'd127, 8'd191, 8'd153, 8'd239, 8'd255};
        ev = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd128, 8'd127, 8'd255,
               8'd200, 8'd200, 8'd200, 8'd200, 8'd125, 8'd175, 8'd255};

        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_out", {6'd0, in_ready, out_valid, h, s, v}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // out_ready while nothing is valid does nothing.
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        chk("idle_oready", {30'd0, out_valid, in_ready}, 32'd1);

        // Directed vectors.
        for (int i = 0; i < 15; i++) begin
            send($sformatf("vec%0d", i), vr[i], vg[i], vb[i], vm[i]);
            expect_hsv($sformatf("vec%0d", i), eh[i], es[i], ev[i]);
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure: held 20 cycles with in_valid asserted.
        send("bp", 8'd200, 8'd100, 8'd50, 1'b0);
        snap = {8'd0, h, s, v};
        in_valid = 1'b1;
        r = 8'd1; g = 8'd2; b = 8'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("bp_hold", {6'd0, out_valid, in_ready, h, s, v},
                {6'd0, 1'b1, 1'b0, snap[23:0]});
        end
        in_valid = 1'b0;
        expect_hsv("bp", 8'd14, 8'd191, 8'd200);
        release_out("bp");

        // Reset in the middle of DIVIDE aborts the pixel.
        r = 8'd0; g = 8'd255; b = 8'd0; mode = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst", {6'd0, in_ready, out_valid, h, s, v}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        send("after_rst", 8'd0, 8'd0, 8'd255, 1'b0);
        expect_hsv("after_rst", 8'd170, 8'd255, 8'd255);
        release_out("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rgb2hsv_stream.md
RGB2HSV_STREAM -- requirements
Module: rgb2hsv_stream

Interface
- REQ-001 The module SHALL have parameter W, default 8: bit width of each colour channel and each output component, legal range 4..12.
- REQ-002 The module SHALL have localparam MAXV = 2^W-1: full-scale value used in all scaling.
- REQ-003 Port `clock`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-004 Port `reset`, input, 1 bit: synchronous, active-low reset.
- REQ-005 Port `in_valid`, input, 1 bit: the pixel on r/g/b/mode is valid.
- REQ-006 Port `in_ready`, output, 1 bit: the block can accept a pixel.
- REQ-007 Port `r`, `g`, `b`, input, W bits each: unsigned colour channels.
- REQ-008 Port `mode`, input, 1 bit: 0 selects HSV, 1 selects HSL; sampled with the pixel.
- REQ-009 Port `out_valid`, output, 1 bit: h/s/v hold a valid result.
- REQ-010 Port `out_ready`, input, 1 bit: the consumer accepts the result.
- REQ-011 Port `h`, `s`, `v`, output, W bits each: hue, saturation, and value (HSV) or lightness (HSL).

Function
- REQ-012 The FSM SHALL have states IDLE, MINMAX, SETUP, DIVIDE and HOLD.
- REQ-013 `in_ready` SHALL be 1 only in IDLE; an accept is `in_valid && in_ready`, and on accept r/g/b/mode SHALL be latched and the FSM SHALL move to MINMAX.
- REQ-014 MINMAX (1 cycle) SHALL compute max and min of the latched channels; on a tie for max, r beats g and g beats b.
- REQ-015 SETUP (1 cycle) SHALL compute delta = max-min, the saturation divide operands and the hue divide operands, per REQ-016 to REQ-019.
- REQ-016 In HSV mode, saturation SHALL use numerator MAXV*delta and divisor max.
- REQ-017 In HSL mode, with sum = max+min, saturation SHALL use divisor sum if sum <= MAXV, else divisor 2*MAXV-sum; the third output SHALL be sum>>1.
- REQ-018 The hue sector SHALL be chosen by the max channel:
  - r: diff = g-b, offset 0;
  - g: diff = b-r, offset MAXV/3 (integer);
  - b: diff = r-g, offset 2*MAXV/3 (integer).
- REQ-019 The hue numerator SHALL be MAXV*|diff|, the hue divisor 6*delta, and the sign of diff SHALL be recorded as neg.
- REQ-020 DIVIDE SHALL run two restoring dividers in parallel for exactly W cycles, producing one quotient bit per cycle MSB-first, giving W-bit floor quotients qs and qh.
- REQ-021 No divider IP SHALL be used.
- REQ-022 Zero handling: a zero divisor (delta=0, or max=0, or HSL divisor 0) SHALL force the corresponding quotient to 0 with no divide-by-zero state.
- REQ-023 Hue result SHALL be:
  - if neg && qh>offset: MAXV-qh+offset;
  - else if neg: offset-qh;
  - else: offset+qh.
  - All arithmetic SHALL be carried at W+2 bits and truncated to W bits.
- REQ-024 On leaving DIVIDE, h/s/v SHALL be registered and the FSM SHALL enter HOLD with `out_valid`=1.
- REQ-025 Latency from the accept edge to `out_valid` rising SHALL be exactly W+3 cycles.
- REQ-026 In HOLD, h/s/v/out_valid SHALL stay stable while `out_ready`=0.
- REQ-027 When `out_ready`=1 in HOLD, the FSM SHALL return to IDLE next cycle with `out_valid`=0 and `in_ready`=1.
- REQ-028 Minimum pixel period SHALL be W+5 cycles; no input is accepted outside IDLE, and inputs changing mid-computation SHALL have no effect.
- REQ-029 `out_ready` asserted while `out_valid`=0 SHALL have no effect.

Reset
- REQ-030 While `reset`=0 at a clock edge, the FSM SHALL enter IDLE and set in_ready=0, out_valid=0, h=s=v=0, clearing all divider and pipeline state.
- REQ-031 `in_ready` SHALL rise on the first edge with `reset`=1.
- REQ-032 Reset asserted mid-DIVIDE or in HOLD SHALL abort the pixel with no later out_valid for it.

Verification (W=8)
- REQ-033 Primary colours, HSV: (255,0,0) -> h=0,s=255,v=255; (0,255,0) -> h=85; (0,0,255) -> h=170; out_valid exactly 11 cycles after accept.
- REQ-034 Tie and wrap: (255,0,255) HSV -> r-sector, neg, qh=42, h=213, s=255, v=255.
- REQ-035 Degenerate inputs: (0,0,0) -> h=s=v=0; (128,128,128) -> h=0,s=0,v=128; no X on outputs.
- REQ-036 HSL mode: (255,0,0),mode=1 -> h=0,s=255,v=127; (255,255,255),mode=1 -> s=0 (divisor 0), v=255.
- REQ-037 Backpressure: out_ready=0 for 20 cycles -> outputs stable and in_ready=0 throughout, in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- REQ-038 Reset mid-DIVIDE: drive reset=0 at accept+5 -> out_valid never asserts for that pixel, and the next pixel converts correctly.
